// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/gnt/rvalid data bus, formats load data,
// builds store byte enables and registers the write-back controls.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reg_wr_in,
  input  logic        mem2reg_sel_in,
  input  logic        mem_wr_in,
  input  logic        mem_rd_in,
  input  logic [2:0]  mem_op_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg2_data_in,
  input  logic [4:0]  reg_wb_addr_in,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_out,
  output logic        wb_reg_wr,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_data,
  output logic        misalign_exc,
  output logic        bus_err_exc,
  output logic        dbg_state
);

  // Bus handshake: a request is accepted in the cycle where dbus_req and
  // dbus_gnt are both high; a load then completes in the first later cycle
  // with dbus_rvalid high. Request signals stay stable until granted.
  typedef enum logic {IDLE = 1'b0, WAIT_RD = 1'b1} state_t;

  localparam logic [7:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off;
  logic        is_byte, is_half, misaligned;
  logic [3:0]  be_val;
  logic [31:0] wdata_val, load_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        sign_ext;
  logic        pending, done, mis_pulse, err_pulse;

  always_comb begin
    off        = alu_result_in[1:0];
    is_byte    = (mem_op_in == 3'b000) || (mem_rd_in && mem_op_in == 3'b100);
    is_half    = (mem_op_in == 3'b001) || (mem_rd_in && mem_op_in == 3'b101);
    misaligned = is_half ? off[0] : (is_byte ? 1'b0 : (off != 2'b00));
    if (is_byte) begin
      be_val    = 4'b0001 << off;
      wdata_val = {4{reg2_data_in[7:0]}};
    end else if (is_half) begin
      be_val    = 4'b0011 << off;
      wdata_val = {2{reg2_data_in[15:0]}};
    end else begin
      be_val    = 4'b1111;
      wdata_val = reg2_data_in;
    end
    lane_byte = 8'(dbus_rdata >> {off, 3'b000});
    lane_half = 16'(dbus_rdata >> {off, 3'b000});
    sign_ext  = ~mem_op_in[2];
    if (is_byte)      load_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
    else if (is_half) load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
    else              load_data = dbus_rdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'd0;
    dbus_be    = 4'd0;
    dbus_wdata = 32'd0;
    pending    = 1'b0;
    done       = 1'b0;
    mis_pulse  = 1'b0;
    err_pulse  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_rd_in || mem_wr_in) begin
          pending = 1'b1;
          if (misaligned) begin
            done      = 1'b1;
            mis_pulse = 1'b1;
          end else begin
            dbus_req   = 1'b1;
            dbus_we    = mem_wr_in;
            dbus_addr  = {alu_result_in[31:2], 2'b00};
            dbus_be    = be_val;
            dbus_wdata = wdata_val;
            if (dbus_gnt) begin
              if (mem_rd_in) begin
                state_d = WAIT_RD;
                cnt_d   = 8'd0;
              end else begin
                done = 1'b1;
              end
            end
          end
        end
      end
      WAIT_RD: begin
        pending = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (dbus_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          // Final wait cycle without data: give up and report a bus error.
          done      = 1'b1;
          err_pulse = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_out = pending & ~done;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stalled cycles send a bubble; address and data keep their last value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_reg_wr    <= 1'b0;
      wb_reg_addr  <= 5'd0;
      wb_data      <= 32'd0;
      misalign_exc <= 1'b0;
      bus_err_exc  <= 1'b0;
    end else begin
      misalign_exc <= mis_pulse;
      bus_err_exc  <= err_pulse;
      if (stall_out) begin
        wb_reg_wr <= 1'b0;
      end else begin
        wb_reg_wr   <= reg_wr_in & ~(mis_pulse | err_pulse);
        wb_reg_addr <= reg_wb_addr_in;
        wb_data     <= mem2reg_sel_in ? load_data : alu_result_in;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: an arithmetic model of the access rules
// predicts bus signals, stalls and write-back results.
module tb_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        reg_wr_in, mem2reg_sel_in, mem_wr_in, mem_rd_in;
  logic [2:0]  mem_op_in;
  logic [31:0] alu_result_in, reg2_data_in;
  logic [4:0]  reg_wb_addr_in;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        stall_out, wb_reg_wr;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_data;
  logic        misalign_exc, bus_err_exc, dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] load_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .reg_wr_in(reg_wr_in), .mem2reg_sel_in(mem2reg_sel_in),
    .mem_wr_in(mem_wr_in), .mem_rd_in(mem_rd_in), .mem_op_in(mem_op_in),
    .alu_result_in(alu_result_in), .reg2_data_in(reg2_data_in),
    .reg_wb_addr_in(reg_wb_addr_in),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .stall_out(stall_out), .wb_reg_wr(wb_reg_wr), .wb_reg_addr(wb_reg_addr),
    .wb_data(wb_data), .misalign_exc(misalign_exc), .bus_err_exc(bus_err_exc),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] op, input bit is_load);
    if (op == 3'd0 || (is_load && op == 3'd4)) return 1;
    if (op == 3'd1 || (is_load && op == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic bit exp_mis(input int sz, input logic [31:0] a);
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input int sz, input logic [31:0] a);
    return 4'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
    if (sz == 1) return 32'(d[7:0]) * 32'h01010101;
    if (sz == 2) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd,
                                           input logic [31:0] a,
                                           input logic [2:0] op);
    int sz;
    longint unsigned v, mask;
    sz = acc_size(op, 1'b1);
    if (sz == 4) return rd;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v = (64'(rd) >> (8 * int'(a[1:0]))) & mask;
    if (op[2] == 1'b0 && v >= (mask + 64'd1) / 2) v = v + (64'hFFFFFFFF - mask);
    return 32'(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    reg_wr_in = 0; mem2reg_sel_in = 0; mem_wr_in = 0; mem_rd_in = 0;
    mem_op_in = 0; alu_result_in = 0; reg2_data_in = 0; reg_wb_addr_in = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [2:0] op, input logic [31:0] a,
                            input logic [4:0] rd);
    reg_wr_in = 1; mem2reg_sel_in = 1; mem_rd_in = 1; mem_wr_in = 0;
    mem_op_in = op; alu_result_in = a; reg_wb_addr_in = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    #12;
    n_tests++; if (wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wb_reg_wr got %0h exp 0", wb_reg_wr); end
    n_tests++; if (wb_reg_addr !== 5'd0) begin n_fail++; $display("FAIL rst_wb_reg_addr got %0h exp 0", wb_reg_addr); end
    n_tests++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_wb_data got %0h exp 0", wb_data); end
    n_tests++; if ({misalign_exc, bus_err_exc} !== 2'b00) begin n_fail++; $display("FAIL rst_exc got %b exp 00", {misalign_exc, bus_err_exc}); end
    n_tests++; if ({dbus_req, dbus_we, stall_out} !== 3'b000) begin n_fail++; $display("FAIL rst_bus got %b exp 000", {dbus_req, dbus_we, stall_out}); end
    n_tests++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_state got %0h exp 0", dbg_state); end
    @(negedge clk); rstn = 1;
    tick();
  endtask

  task automatic test_alu();
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] res;
    for (int i = 0; i < 8; i++) begin
      wr  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rd  = (i == 0) ? 5'd5 : 5'($urandom_range(0, 31));
      res = (i == 0) ? 32'h1234 : $urandom;
      idle_inputs();
      reg_wr_in = wr; reg_wb_addr_in = rd; alu_result_in = res;
      mid();
      n_tests++; if ({stall_out, dbus_req} !== 2'b00) begin n_fail++; $display("FAIL alu_stall_req got %b exp 00", {stall_out, dbus_req}); end
      tick();
      n_tests++; if (wb_reg_wr !== wr) begin n_fail++; $display("FAIL alu_wb_reg_wr got %0h exp %0h", wb_reg_wr, wr); end
      n_tests++; if (wb_reg_addr !== rd) begin n_fail++; $display("FAIL alu_wb_reg_addr got %0d exp %0d", wb_reg_addr, rd); end
      n_tests++; if (wb_data !== res) begin n_fail++; $display("FAIL alu_wb_data got %h exp %h", wb_data, res); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  op;
    logic [31:0] a, d;
    int          sz;
    bit          mis;
    for (int i = 0; i < 10; i++) begin
      op = (i == 0) ? 3'd0 : 3'($urandom_range(0, 2));
      sz = acc_size(op, 1'b0);
      a  = (i == 0) ? 32'h103 : $urandom;
      if (i != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      d  = (i == 0) ? 32'hAB : $urandom;
      mis = exp_mis(sz, a);
      idle_inputs();
      mem_wr_in = 1; mem_op_in = op; alu_result_in = a; reg2_data_in = d;
      reg_wb_addr_in = 5'($urandom_range(0, 31)); dbus_gnt = 1;
      mid();
      n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL st_stall got %0h exp 0", stall_out); end
      n_tests++; if (dbus_req !== !mis) begin n_fail++; $display("FAIL st_req got %0h exp %0h", dbus_req, !mis); end
      if (!mis) begin
        n_tests++; if (dbus_we !== 1'b1) begin n_fail++; $display("FAIL st_we got %0h exp 1", dbus_we); end
        n_tests++; if (dbus_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL st_addr got %h exp %h", dbus_addr, {a[31:2], 2'b00}); end
        n_tests++; if (dbus_be !== exp_be(sz, a)) begin n_fail++; $display("FAIL st_be got %b exp %b", dbus_be, exp_be(sz, a)); end
        n_tests++; if (dbus_wdata !== exp_wdata(sz, d)) begin n_fail++; $display("FAIL st_wdata got %h exp %h", dbus_wdata, exp_wdata(sz, d)); end
      end
      tick();
      n_tests++; if (wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL st_wb_reg_wr got %0h exp 0", wb_reg_wr); end
      n_tests++; if (misalign_exc !== mis) begin n_fail++; $display("FAIL st_misalign got %0h exp %0h", misalign_exc, mis); end
      idle_inputs();
      tick();
      n_tests++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL st_misalign_pulse got %0h exp 0", misalign_exc); end
    end
  endtask

  task automatic test_load();
    logic [2:0]  op;
    logic [31:0] a, rdat;
    logic [4:0]  rd;
    int          sz;
    bit          mis;
    for (int i = 0; i < 14; i++) begin
      op   = (i == 0) ? 3'd0 : (i == 1) ? 3'd4 : (i == 2) ? 3'd1 : load_ops[$urandom_range(0, 4)];
      sz   = acc_size(op, 1'b1);
      a    = (i < 2) ? 32'h102 : (i == 2) ? 32'h101 : $urandom;
      if (i > 2 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      rdat = (i < 2) ? 32'h0080_0000 : $urandom;
      rd   = 5'($urandom_range(1, 31));
      mis  = exp_mis(sz, a);
      idle_inputs();
      drive_load(op, a, rd);
      dbus_gnt = 1;
      mid();
      n_tests++; if (dbus_req !== !mis) begin n_fail++; $display("FAIL ld_req got %0h exp %0h", dbus_req, !mis); end
      n_tests++; if (stall_out !== !mis) begin n_fail++; $display("FAIL ld_stall0 got %0h exp %0h", stall_out, !mis); end
      if (!mis) begin
        n_tests++; if ({dbus_we, dbus_be} !== {1'b0, exp_be(sz, a)}) begin n_fail++; $display("FAIL ld_we_be got %b exp %b", {dbus_we, dbus_be}, {1'b0, exp_be(sz, a)}); end
        n_tests++; if (dbus_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL ld_addr got %h exp %h", dbus_addr, {a[31:2], 2'b00}); end
      end
      tick();
      n_tests++; if (wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL ld_wb_bubble got %0h exp 0", wb_reg_wr); end
      n_tests++; if (misalign_exc !== mis) begin n_fail++; $display("FAIL ld_misalign got %0h exp %0h", misalign_exc, mis); end
      if (!mis) begin
        dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = rdat;
        mid();
        n_tests++; if ({stall_out, dbus_req} !== 2'b00) begin n_fail++; $display("FAIL ld_stall1 got %b exp 00", {stall_out, dbus_req}); end
        tick();
        n_tests++; if (wb_reg_wr !== 1'b1) begin n_fail++; $display("FAIL ld_wb_reg_wr got %0h exp 1", wb_reg_wr); end
        n_tests++; if (wb_reg_addr !== rd) begin n_fail++; $display("FAIL ld_wb_reg_addr got %0d exp %0d", wb_reg_addr, rd); end
        n_tests++; if (wb_data !== exp_load(rdat, a, op)) begin n_fail++; $display("FAIL ld_wb_data op%0d got %h exp %h", op, wb_data, exp_load(rdat, a, op)); end
      end
      idle_inputs();
      tick();
      n_tests++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL ld_misalign_pulse got %0h exp 0", misalign_exc); end
    end
  endtask

  task automatic test_gnt_wait();
    logic [31:0] rdat;
    int          dly;
    rdat = $urandom;
    dly  = $urandom_range(0, 2);
    idle_inputs();
    drive_load(3'd2, 32'h200, 5'd7);
    for (int c = 0; c < 4; c++) begin
      dbus_gnt = (c == 3);
      mid();
      n_tests++; if ({dbus_req, stall_out} !== 2'b11) begin n_fail++; $display("FAIL gw_req_stall c%0d got %b exp 11", c, {dbus_req, stall_out}); end
      n_tests++; if ({dbus_addr, dbus_be} !== {32'h200, 4'hF}) begin n_fail++; $display("FAIL gw_addr_be c%0d got %h/%b exp 200/1111", c, dbus_addr, dbus_be); end
      tick();
      n_tests++; if (wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL gw_bubble c%0d got %0h exp 0", c, wb_reg_wr); end
    end
    dbus_gnt = 0;
    for (int c = 0; c < dly; c++) begin
      mid();
      n_tests++; if ({dbus_req, stall_out} !== 2'b01) begin n_fail++; $display("FAIL gw_wait c%0d got %b exp 01", c, {dbus_req, stall_out}); end
      tick();
    end
    dbus_rvalid = 1; dbus_rdata = rdat;
    mid();
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL gw_stall_end got %0h exp 0", stall_out); end
    tick();
    n_tests++; if ({wb_reg_wr, wb_reg_addr} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL gw_wb_ctl got %h exp 27", {wb_reg_wr, wb_reg_addr}); end
    n_tests++; if (wb_data !== rdat) begin n_fail++; $display("FAIL gw_wb_data got %h exp %h", wb_data, rdat); end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    logic [31:0] res;
    int          n;
    // Grant and read data without an access must not disturb an ALU op.
    res = $urandom;
    idle_inputs();
    reg_wr_in = 1; reg_wb_addr_in = 5'd3; alu_result_in = res;
    dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = ~res;
    mid();
    n_tests++; if ({dbus_req, stall_out} !== 2'b00) begin n_fail++; $display("FAIL stray_req_stall got %b exp 00", {dbus_req, stall_out}); end
    tick();
    n_tests++; if (wb_data !== res || wb_reg_wr !== 1'b1) begin n_fail++; $display("FAIL stray_wb got %h/%0h exp %h/1", wb_data, wb_reg_wr, res); end
    idle_inputs();
    drive_load(3'd2, 32'h40, 5'd11);
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (bus_err_exc === 1'b1) break;
    end
    n_tests++; if (n !== TMO) begin n_fail++; $display("FAIL to_latency got %0d exp %0d", n, TMO); end
    n_tests++; if (wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL to_wb_reg_wr got %0h exp 0", wb_reg_wr); end
    idle_inputs();
    res = $urandom;
    reg_wr_in = 1; reg_wb_addr_in = 5'd9; alu_result_in = res | 32'h1;
    dbus_rvalid = 1; dbus_rdata = $urandom;
    mid();
    n_tests++; if ({dbus_req, stall_out} !== 2'b00) begin n_fail++; $display("FAIL to_late_stall got %b exp 00", {dbus_req, stall_out}); end
    tick();
    n_tests++; if (bus_err_exc !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got %0h exp 0", bus_err_exc); end
    n_tests++; if (wb_data !== (res | 32'h1) || wb_reg_wr !== 1'b1) begin n_fail++; $display("FAIL to_late_wb got %h/%0h exp %h/1", wb_data, wb_reg_wr, res | 32'h1); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    drive_load(3'd2, 32'h80, 5'd12);
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0;
    tick();
    #2;
    rstn = 0;
    idle_inputs();
    #1;
    n_tests++; if ({wb_reg_wr, wb_reg_addr} !== 6'd0) begin n_fail++; $display("FAIL rm_wb_ctl got %h exp 0", {wb_reg_wr, wb_reg_addr}); end
    n_tests++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL rm_wb_data got %h exp 0", wb_data); end
    n_tests++; if ({dbg_state, stall_out} !== 2'b00) begin n_fail++; $display("FAIL rm_state_stall got %b exp 00", {dbg_state, stall_out}); end
    @(negedge clk); rstn = 1;
    tick();
    dbus_rvalid = 1; dbus_rdata = 32'hDEADBEEF;
    mid();
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL rm_late_stall got %0h exp 0", stall_out); end
    tick();
    n_tests++; if ({wb_reg_wr, wb_data} !== 33'd0) begin n_fail++; $display("FAIL rm_late_wb got %h exp 0", {wb_reg_wr, wb_data}); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_gnt_wait();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
